// File: rtl/sel_gen.sv
// Selection-code generator for the sel_mem write side: walks codes 0..N_SEL-1,
// strobes each for EN_CYC cycles, then waits for a datapath acknowledge.
module sel_gen #(
  parameter int WIDTH  = 4,
  parameter int N_SEL  = 9,
  parameter int EN_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             step_ack,
  output logic [WIDTH-1:0] sel_out,
  output logic             sel_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] IDX_LAST = WIDTH'(N_SEL - 1);
  localparam logic [3:0]       CNT_LAST = 4'(EN_CYC - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] sel_d;
  logic             en_d, busy_d, done_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (step_ack) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + WIDTH'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything but leaves the index where it stopped.
    if (abort) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
    end

    // Outputs are registered versions of the next-state decode, so they move
    // on the same edge as the state; sel_out only changes while loading.
    sel_d  = (state_d == S_LOAD) ? idx_d : sel_out;
    en_d   = (state_d == S_LOAD);
    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_out <= '0;
      sel_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_out <= sel_d;
      sel_en  <= en_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_sel_gen.sv
// Bench for sel_gen: two instances (9 codes/2-cycle strobe and 1 code/1-cycle
// strobe) checked every cycle against a run-level model, plus directed pins.
module tb_sel_gen;

  localparam int W = 4;
  localparam int NS[2] = '{9, 1};
  localparam int EC[2] = '{2, 1};

  localparam int P_IDLE   = 0;
  localparam int P_STROBE = 1;
  localparam int P_WAIT   = 2;
  localparam int P_END    = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         step_ack = 1'b0;
  logic [W-1:0] sel_out[2];
  logic         sel_en[2];
  logic         busy[2];
  logic         done[2];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on = 1'b0;

  // Model: what the run looks like, in codes and remaining strobe cycles.
  int   m_phase[2] = '{P_IDLE, P_IDLE};
  int   m_code[2]  = '{0, 0};
  int   m_left[2]  = '{0, 0};
  int   e_sel[2]   = '{0, 0};
  logic e_en[2]    = '{1'b0, 1'b0};
  logic e_busy[2]  = '{1'b0, 1'b0};
  logic e_done[2]  = '{1'b0, 1'b0};

  sel_gen #(.WIDTH(W), .N_SEL(9), .EN_CYC(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .step_ack(step_ack),
    .sel_out(sel_out[0]), .sel_en(sel_en[0]), .busy(busy[0]), .done(done[0])
  );

  sel_gen #(.WIDTH(W), .N_SEL(1), .EN_CYC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .step_ack(step_ack),
    .sel_out(sel_out[1]), .sel_en(sel_en[1]), .busy(busy[1]), .done(done[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   p, c, l, s;
      logic en, b, dn;
      p = m_phase[d]; c = m_code[d]; l = m_left[d]; s = e_sel[d];
      en = e_en[d]; b = e_busy[d]; dn = e_done[d];
      if (!rst_n) begin
        p = P_IDLE; c = 0; l = 0; s = 0; en = 1'b0; b = 1'b0; dn = 1'b0;
      end else if (abort) begin
        p = P_IDLE; en = 1'b0; b = 1'b0; dn = 1'b0;
      end else begin
        case (p)
          P_IDLE: if (start) begin
            c = 0; s = 0; l = EC[d]; p = P_STROBE; en = 1'b1; b = 1'b1;
          end
          P_STROBE: begin
            l = l - 1;
            if (l == 0) begin p = P_WAIT; en = 1'b0; end
          end
          P_WAIT: if (step_ack) begin
            if (c == NS[d] - 1) begin
              p = P_END; dn = 1'b1; b = 1'b0;
            end else begin
              c = c + 1; s = c; l = EC[d]; p = P_STROBE; en = 1'b1;
            end
          end
          default: begin p = P_IDLE; dn = 1'b0; end
        endcase
      end
      m_phase[d] <= p; m_code[d] <= c; m_left[d] <= l; e_sel[d] <= s;
      e_en[d] <= en; e_busy[d] <= b; e_done[d] <= dn;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        check("sel_out", d, 32'(sel_out[d]), 32'(e_sel[d]));
        check("sel_en", d, 32'(sel_en[d]), 32'(e_en[d]));
        check("busy", d, 32'(busy[d]), 32'(e_busy[d]));
        check("done", d, 32'(done[d]), 32'(e_done[d]));
      end
    end
  end

  initial begin
    int    en_cnt, busy_cnt, done_cnt, rises, wait3, budget;
    bit    pe, seen_done, ack3_sent, ok;
    int    codes[$];
    logic [W-1:0] held;

    // Reset held two cycles with start high, then released.
    rst_n = 1'b0; start = 1'b1; step_ack = 1'b1;
    @(posedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full run with step_ack tied high.
    en_cnt = 0; busy_cnt = 0; done_cnt = 0; pe = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("release_load_en", 0, 32'(sel_en[0]), 1);
        check("release_load_sel", 0, 32'(sel_out[0]), 0);
        start = 1'b0;
      end
      if (sel_en[0]) en_cnt++;
      if (busy[0]) busy_cnt++;
      if (done[0]) done_cnt++;
      if (sel_en[0] && !pe) codes.push_back(int'(sel_out[0]));
      pe = sel_en[0];
    end
    check("full_en_cycles", 0, 32'(en_cnt), 18);
    check("full_busy_cycles", 0, 32'(busy_cnt), 27);
    check("full_done_pulses", 0, 32'(done_cnt), 1);
    check("full_code_count", 0, 32'(codes.size()), 9);
    foreach (codes[i]) check("full_code_seq", 0, 32'(codes[i]), 32'(i));

    // Delayed acknowledge on code 3, ignored acknowledge during LOAD of code 2.
    step_ack = 1'b0; start = 1'b1;
    rises = 0; wait3 = 0; pe = 1'b0; seen_done = 1'b0; ack3_sent = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (ack3_sent) begin
        check("ack3_next_sel", 0, 32'(sel_out[0]), 4);
        check("ack3_next_en", 0, 32'(sel_en[0]), 1);
        ack3_sent = 1'b0;
      end
      if (sel_en[0] && !pe) rises++;
      pe = sel_en[0];
      if (done[0]) seen_done = 1'b1;
      if (sel_en[0]) step_ack = (sel_out[0] == 4'd2);
      else if (busy[0]) begin
        if (sel_out[0] == 4'd3) begin
          wait3++;
          if (wait3 < 5) step_ack = 1'b0;
          else begin
            check("hold3_sel", 0, 32'(sel_out[0]), 3);
            check("hold3_en", 0, 32'(sel_en[0]), 0);
            step_ack = 1'b1;
            ack3_sent = 1'b1;
          end
        end else step_ack = 1'b1;
      end else step_ack = 1'b0;
    end
    check("delayed_run_done", 0, 32'(seen_done), 1);
    check("delayed_strobes", 0, 32'(rises), 9);
    @(negedge clk);

    // Abort during the strobe window of code 4, then restart.
    step_ack = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (budget = 0; budget < 100 && !ok; budget++) begin
      if (sel_en[0] && sel_out[0] == 4'd4) ok = 1'b1;
      else @(negedge clk);
    end
    check("abort_reach_code4", 0, 32'(ok), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_en", 0, 32'(sel_en[0]), 0);
    check("abort_busy", 0, 32'(busy[0]), 0);
    check("abort_done", 0, 32'(done[0]), 0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_sel", 0, 32'(sel_out[0]), 0);
    check("restart_en", 0, 32'(sel_en[0]), 1);

    // Simultaneous events in WAIT and IDLE.
    step_ack = 1'b0;
    ok = 1'b0;
    for (budget = 0; budget < 20 && !ok; budget++) begin
      if (busy[0] && !sel_en[0]) ok = 1'b1;
      else @(negedge clk);
    end
    check("reach_wait", 0, 32'(ok), 1);
    held = sel_out[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_wait_busy", 0, 32'(busy[0]), 1);
    check("start_in_wait_en", 0, 32'(sel_en[0]), 0);
    abort = 1'b1; step_ack = 1'b1;
    @(negedge clk);
    abort = 1'b0; step_ack = 1'b0;
    check("abort_ack_busy", 0, 32'(busy[0]), 0);
    check("abort_ack_sel", 0, 32'(sel_out[0]), 32'(held));
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 0, 32'(busy[0]), 0);
    check("start_abort_en", 0, 32'(sel_en[0]), 0);

    // Single-code, single-cycle strobe configuration.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("n1_strobe_en", 1, 32'(sel_en[1]), 1);
    check("n1_strobe_sel", 1, 32'(sel_out[1]), 0);
    @(negedge clk);
    check("n1_wait_en", 1, 32'(sel_en[1]), 0);
    check("n1_wait_busy", 1, 32'(busy[1]), 1);
    step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    check("n1_done", 1, 32'(done[1]), 1);
    check("n1_done_busy", 1, 32'(busy[1]), 0);
    @(negedge clk);
    check("n1_done_clear", 1, 32'(done[1]), 0);

    // Randomised traffic, including occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start    = ($urandom % 4) == 0;
      abort    = ($urandom % 40) == 0;
      step_ack = ($urandom % 3) == 0;
      rst_n    = ($urandom % 300) != 0;
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; step_ack = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
